unified_mem_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the core's fetch port and its load/store port. Each request is captured at grant and driven to memory with a `mem_en`/`mem_ready` handshake. Completion is returned to the requester as a one-cycle `done` pulse with registered read data. The block sits between the RISC-V core's fetch/LSU interfaces and the memory macro, and lets the core run from a single memory with variable-latency accesses.

---
 rtl/unified_mem_arbiter_if.sv | 43 ++++
 rtl/unified_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Core-side fetch/LSU request ports and memory-macro port of the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              err;
    logic              busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported instruction/data memory between fetch and load/store,
// alternating grants on conflict and aborting accesses that exceed TIMEOUT cycles.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  reset,
    unified_mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } acc_t;

    state_e           state_q;
    state_e           state_d;
    grant_e           last_grant_q;
    acc_t             acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic grant_fetch_c;
    logic grant_data_c;
    logic complete_c;
    logic timeout_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant decision and memory-port decode
    always_comb begin
        state_d       = state_q;
        grant_fetch_c = 1'b0;
        grant_data_c  = 1'b0;
        complete_c    = 1'b0;
        timeout_c     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Data wins a conflict unless it won the previous grant
                if (bus.d_req && (!bus.if_req || (last_grant_q == GRANT_FETCH))) begin
                    grant_data_c = 1'b1;
                end else if (bus.if_req) begin
                    grant_fetch_c = 1'b1;
                end
                if (grant_data_c || grant_fetch_c) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = acc_q.we;
                bus.mem_addr  = acc_q.addr;
                bus.mem_wdata = acc_q.wdata;
                bus.mem_be    = acc_q.be;
                // A ready on the last allowed cycle still counts as a normal completion
                if (bus.mem_ready) begin
                    complete_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_c = 1'b1;
                end
                if (complete_c || timeout_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and registered completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_FETCH;
            acc_q        <= '0;
            cnt_q        <= '0;
            bus.if_rdata <= '0;
            bus.if_done  <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_done   <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.err     <= 1'b0;

            if (grant_data_c) begin
                last_grant_q <= GRANT_DATA;
                acc_q.addr   <= bus.d_addr;
                acc_q.we     <= bus.d_we;
                acc_q.wdata  <= bus.d_wdata;
                acc_q.be     <= bus.d_be;
                cnt_q        <= '0;
            end else if (grant_fetch_c) begin
                last_grant_q <= GRANT_FETCH;
                acc_q.addr   <= bus.if_addr;
                acc_q.we     <= 1'b0;
                acc_q.wdata  <= '0;
                acc_q.be     <= '1;
                cnt_q        <= '0;
            end else if (state_q == ACC) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (complete_c || timeout_c) begin
                bus.err <= timeout_c;
                if (last_grant_q == GRANT_DATA) begin
                    bus.d_done  <= 1'b1;
                    bus.d_rdata <= complete_c ? bus.mem_rdata : '0;
                end else begin
                    bus.if_done  <= 1'b1;
                    bus.if_rdata <= complete_c ? bus.mem_rdata : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Random two-requester traffic against a timestamp-based transaction model with a
// variable-latency memory, including timeouts and an asynchronous reset mid-access.
module tb_unified_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    unified_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int t = -1;

    // Requester agents: a request stays pending until its done cycle
    logic          f_pend;
    logic [AW-1:0] f_addr;
    logic          d_pend;
    logic          d_we_m;
    logic [AW-1:0] d_addr_m;
    logic [DW-1:0] d_wdata_m;
    logic [BW-1:0] d_be_m;

    // Transaction in flight, described by its grant cycle and length
    logic          tx_act;
    int            tx_g;
    int            tx_l;
    int            tx_ready;
    logic          tx_data;
    logic          tx_err;
    logic          tx_we;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_wdata;
    logic [BW-1:0] tx_be;
    logic [DW-1:0] tx_mem_data;
    logic [DW-1:0] tx_rdata;
    int            free_cyc;
    logic          last_data;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_d_rdata;

    logic [DW-1:0] mem_model [logic [AW-1:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 32'h0000_2000 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] w;
        w = mem_rd(a);
        for (int b = 0; b < BW; b++) begin
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem_model[a] = w;
    endtask

    task automatic model_clear();
        tx_act       = 1'b0;
        tx_ready     = -1;
        f_pend       = 1'b0;
        d_pend       = 1'b0;
        last_data    = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        free_cyc     = 0;
    endtask

    task automatic drive_idle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic check_reset_outputs(input string p);
        check_eq({p, "_mem_en"},    bus.mem_en,    0);
        check_eq({p, "_mem_we"},    bus.mem_we,    0);
        check_eq({p, "_mem_addr"},  bus.mem_addr,  0);
        check_eq({p, "_mem_wdata"}, bus.mem_wdata, 0);
        check_eq({p, "_mem_be"},    bus.mem_be,    0);
        check_eq({p, "_busy"},      bus.busy,      0);
        check_eq({p, "_if_done"},   bus.if_done,   0);
        check_eq({p, "_d_done"},    bus.d_done,    0);
        check_eq({p, "_err"},       bus.err,       0);
        check_eq({p, "_if_rdata"},  bus.if_rdata,  0);
        check_eq({p, "_d_rdata"},   bus.d_rdata,   0);
    endtask

    // One cycle: check outputs for cycle t, then drive the inputs sampled at its end
    task automatic step(input int p_req, input int w_max);
        logic in_acc;
        logic in_resp;
        logic gd;
        logic gf;
        int   w;

        in_acc  = tx_act && (t > tx_g) && (t <= tx_g + tx_l);
        in_resp = tx_act && (t == tx_g + tx_l + 1);
        if (in_resp) begin
            if (tx_data) exp_d_rdata = tx_rdata;
            else exp_if_rdata = tx_rdata;
        end

        check_eq("mem_en",   bus.mem_en,   in_acc);
        check_eq("busy",     bus.busy,     in_acc || in_resp);
        check_eq("if_done",  bus.if_done,  in_resp && !tx_data);
        check_eq("d_done",   bus.d_done,   in_resp && tx_data);
        check_eq("err",      bus.err,      in_resp && tx_err);
        check_eq("if_rdata", bus.if_rdata, exp_if_rdata);
        check_eq("d_rdata",  bus.d_rdata,  exp_d_rdata);
        if (in_acc) begin
            check_eq("mem_addr",  bus.mem_addr,  tx_addr);
            check_eq("mem_we",    bus.mem_we,    tx_we);
            check_eq("mem_be",    bus.mem_be,    tx_be);
            check_eq("mem_wdata", bus.mem_wdata, tx_wdata);
        end

        if (in_resp) begin
            tx_act = 1'b0;
            if (tx_data) d_pend = 1'b0;
            else f_pend = 1'b0;
        end

        if (!f_pend && ($urandom_range(0, 99) < p_req)) begin
            f_pend = 1'b1;
            f_addr = rand_addr();
        end
        if (!d_pend && ($urandom_range(0, 99) < p_req)) begin
            d_pend    = 1'b1;
            d_we_m    = 1'($urandom_range(0, 1));
            d_addr_m  = rand_addr();
            d_wdata_m = $urandom;
            d_be_m    = 4'($urandom_range(1, 15));
        end

        // Arbitration rule: single requester wins; on conflict data unless data went last
        if (!tx_act && (t >= free_cyc)) begin
            gd = d_pend && (!f_pend || !last_data);
            gf = f_pend && !gd;
            if (gd || gf) begin
                tx_act  = 1'b1;
                tx_g    = t;
                tx_data = gd;
                if (gd) begin
                    tx_addr  = d_addr_m;
                    tx_we    = d_we_m;
                    tx_wdata = d_wdata_m;
                    tx_be    = d_be_m;
                end else begin
                    tx_addr  = f_addr;
                    tx_we    = 1'b0;
                    tx_wdata = '0;
                    tx_be    = '1;
                end
                w = int'($urandom_range(0, w_max));
                if (w + 1 <= TO) begin
                    tx_l     = w + 1;
                    tx_err   = 1'b0;
                    tx_ready = t + w + 1;
                end else begin
                    tx_l     = TO;
                    tx_err   = 1'b1;
                    tx_ready = -1;
                end
                tx_mem_data = tx_we ? $urandom : mem_rd(tx_addr);
                if (tx_we && !tx_err) mem_write(tx_addr, tx_wdata, tx_be);
                tx_rdata  = tx_err ? '0 : tx_mem_data;
                free_cyc  = t + tx_l + 2;
                last_data = gd;
            end
        end

        // After the grant the requester may wander; the latched request must not
        bus.if_req  = f_pend;
        bus.if_addr = f_pend ? f_addr : $urandom;
        if (tx_act && !tx_data && (t > tx_g) && ($urandom_range(0, 3) == 0)) begin
            bus.if_req  = 1'($urandom_range(0, 1));
            bus.if_addr = $urandom;
        end
        bus.d_req   = d_pend;
        bus.d_we    = d_we_m;
        bus.d_addr  = d_addr_m;
        bus.d_wdata = d_wdata_m;
        bus.d_be    = d_be_m;
        if (tx_act && tx_data && (t > tx_g) && ($urandom_range(0, 3) == 0)) begin
            bus.d_req   = 1'($urandom_range(0, 1));
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_be    = 4'($urandom_range(0, 15));
        end

        if (tx_act && (t == tx_ready)) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = tx_mem_data;
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
        end
    endtask

    task automatic run(input int n, input int p_req, input int w_max);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t++;
            step(p_req, w_max);
        end
    endtask

    // Busy traffic until the arbiter sits in an access, then pull reset before the edge
    task automatic reset_mid_acc();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            t++;
            step(100, TO + 2);
            hit = tx_act && (t > tx_g) && (t <= tx_g + tx_l);
        end
        check_eq("reach_acc", hit, 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst_acc");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        drive_idle();
        model_clear();
        d_we_m    = 1'b0;
        d_addr_m  = '0;
        d_wdata_m = '0;
        d_be_m    = '0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_clear();
        f_addr    = '0;
        d_we_m    = 1'b0;
        d_addr_m  = '0;
        d_wdata_m = '0;
        d_be_m    = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_init");
        reset = 1'b1;

        run(30, 100, 0);
        run(800, 50, TO + 2);
        run(200, 100, TO + 2);
        reset_mid_acc();
        run(300, 40, TO + 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
